// File: rtl/network_sink_packer.sv
// network_sink_packer
// Buffers network output frames in a DEPTH-entry FIFO and serialises each
// frame onto a SNK_WIDTH-bit valid/ready stream, flagging the last chunk.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   net_valid/net_ready   frame input handshake
//   net_out[NUM_OUT]      frame bits, bit i = output neuron i
//   snk_valid/snk_ready   chunk output handshake
//   snk[SNK_WIDTH]        chunk data; output 0 lands in the MSB of chunk 0
//   snk_last              asserted on the final chunk of a frame
//   fifo_count            frames queued, excluding the one being serialised
//
// Optional feature: define SINK_HEADER_EN to precede every frame with a
// header chunk carrying an 8-bit frame sequence number.

module network_sink_packer #(
   parameter int unsigned NUM_OUT   = 16,
   parameter int unsigned SNK_WIDTH = 8,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   net_valid,
   output logic                   net_ready,
   input  logic [NUM_OUT-1:0]     net_out,
   input  logic                   snk_ready,
   output logic                   snk_valid,
   output logic [SNK_WIDTH-1:0]   snk,
   output logic                   snk_last,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int unsigned NUM_CHUNKS = (NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;
   localparam int unsigned FRAME_W    = NUM_CHUNKS * SNK_WIDTH;
   localparam int unsigned PTR_W      = $clog2(DEPTH);
   localparam int unsigned CNT_W      = PTR_W + 1;
   localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic             ONE_CHUNK = (NUM_CHUNKS == 1);

`ifdef SINK_HEADER_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_HDR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_t;
`endif

   // Chunk k, bit-reversed so the lowest frame bit of the chunk becomes its MSB.
   function automatic logic [SNK_WIDTH-1:0] chunk_of(input logic [FRAME_W-1:0] f,
                                                      input logic [IDX_W-1:0]   k);
      logic [SNK_WIDTH-1:0] c;
      int unsigned          bit_i;
      c = '0;
      for (int unsigned j = 0; j < SNK_WIDTH; j++) begin
         bit_i = 32'(k) * SNK_WIDTH + j;
         if (bit_i < FRAME_W) c[SNK_WIDTH-1-j] = f[bit_i];
      end
      return c;
   endfunction

   logic [NUM_OUT-1:0]   mem_q [DEPTH];
   logic [NUM_OUT-1:0]   mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 net_ready_q, net_ready_d;
   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 valid_q, valid_d;
   logic [SNK_WIDTH-1:0] snk_q, snk_d;
   logic                 last_q, last_d;
`ifdef SINK_HEADER_EN
   logic [7:0]           seq_q, seq_d;
`endif

   logic                 push, pop, hs;
   logic [IDX_W-1:0]     idx_nxt;
   logic [FRAME_W-1:0]   head;

   // FIFO bookkeeping and serialiser next state.
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      snk_d       = snk_q;
      last_d      = last_q;
`ifdef SINK_HEADER_EN
      seq_d       = seq_q;
`endif
      mem_d       = mem_q;
      pop         = 1'b0;
      push        = net_valid && net_ready_q;
      hs          = valid_q && snk_ready;
      idx_nxt     = IDX_W'(idx_q + 1'b1);
      head        = FRAME_W'(mem_q[rd_ptr_q]);

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
`ifdef SINK_HEADER_EN
         S_HDR: begin
            if (hs) begin
               state_d = S_SEND;
               idx_d   = '0;
               snk_d   = chunk_of(frame_q, '0);
               last_d  = ONE_CHUNK;
            end
         end
`endif
         S_SEND: begin
            if (hs) begin
               if (idx_q == LAST_IDX) begin
`ifdef SINK_HEADER_EN
                  seq_d = seq_q + 8'd1;
`endif
                  // Back-to-back: the next frame is popped on this same edge.
                  if (count_q != '0) begin
                     pop = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     valid_d = 1'b0;
                     snk_d   = '0;
                     last_d  = 1'b0;
                  end
               end else begin
                  idx_d  = idx_nxt;
                  snk_d  = chunk_of(frame_q, idx_nxt);
                  last_d = (idx_nxt == LAST_IDX);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Load the FIFO head into the shift register and present its first chunk.
      if (pop) begin
         frame_d = head;
         idx_d   = '0;
         valid_d = 1'b1;
`ifdef SINK_HEADER_EN
         state_d = S_HDR;
         snk_d   = SNK_WIDTH'(seq_d);
         last_d  = 1'b0;
`else
         state_d = S_SEND;
         snk_d   = chunk_of(head, '0);
         last_d  = ONE_CHUNK;
`endif
      end

      if (push) mem_d[wr_ptr_q] = net_out;
      wr_ptr_d    = wr_ptr_q + PTR_W'(push);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      net_ready_d = (count_d != FULL_CNT);
   end

   // Frame storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         net_ready_q <= 1'b1;
         state_q     <= S_IDLE;
         frame_q     <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         snk_q       <= '0;
         last_q      <= 1'b0;
`ifdef SINK_HEADER_EN
         seq_q       <= '0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         net_ready_q <= net_ready_d;
         state_q     <= state_d;
         frame_q     <= frame_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         snk_q       <= snk_d;
         last_q      <= last_d;
`ifdef SINK_HEADER_EN
         seq_q       <= seq_d;
`endif
      end
   end

   assign net_ready  = net_ready_q;
   assign fifo_count = count_q;
   assign snk_valid  = valid_q;
   assign snk        = snk_q;
   assign snk_last   = last_q;

endmodule
